// File: rtl/conv_seq_pkg.sv
// Shared types and derived frame constants for the conv/max-pool frame sequencer.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FIN    = 2'd3
    } seq_state_t;

    function automatic int unsigned calc_n_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Valid convolution, stride 1.
    function automatic int unsigned calc_n_conv(input int unsigned w, input int unsigned h,
                                                input int unsigned k);
        return (w - k + 1) * (h - k + 1);
    endfunction

    // Non-overlapping pooling over the convolution output.
    function automatic int unsigned calc_n_max(input int unsigned w, input int unsigned h,
                                               input int unsigned k, input int unsigned p);
        return ((w - k + 1) / p) * ((h - k + 1) / p);
    endfunction

endpackage

// File: rtl/conv_seq_out_counter.sv
// Saturating event counter with a registered target match and a registered overrun pulse.
module conv_seq_out_counter
    import conv_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             hit,
    output logic             over
);

    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count != '1)) begin
            count_nxt = count + CNT_W'(1);
        end
    end

    // hit tracks the value being stored so it always describes the visible count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            hit   <= 1'b0;
            over  <= 1'b0;
        end else begin
            count <= count_nxt;
            hit   <= (count_nxt == target);
            over  <= !clr && inc && (count == target);
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one frame from frame memory into the conv/max-pool datapath and
// tracks the returning valid pulses until completion or drain timeout.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned IMG_W         = 28,
    parameter int unsigned IMG_H         = 28,
    parameter int unsigned KERNEL        = 3,
    parameter int unsigned POOL          = 2,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] Pixel_In,
    output logic              Pixel_valid,
    input  logic              Con_Valid,
    input  logic              Max_Valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  conv_count,
    output logic [CNT_W-1:0]  max_count
);

    localparam int unsigned N_PIX  = calc_n_pix(IMG_W, IMG_H);
    localparam int unsigned N_CONV = calc_n_conv(IMG_W, IMG_H, KERNEL);
    localparam int unsigned N_MAX  = calc_n_max(IMG_W, IMG_H, KERNEL, POOL);
    localparam int unsigned IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0]  CONV_TGT  = CNT_W'(N_CONV);
    localparam logic [CNT_W-1:0]  MAX_TGT   = CNT_W'(N_MAX);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(DRAIN_TIMEOUT);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              rd_req;
    logic              start_acc;
    logic              timeout;
    logic              count_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en_d1;
    logic [IDLE_W-1:0] idle_cnt;
    logic              conv_hit;
    logic              conv_over;
    logic              max_hit;
    logic              max_over;

    assign count_en = (state == ST_STREAM) || (state == ST_DRAIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        start_acc = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    rd_req = 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Completion takes priority over a coincident timeout.
                if (conv_hit && max_hit) begin
                    state_nxt = ST_FIN;
                end else if (idle_cnt == IDLE_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read issue, two-stage pixel pipe, drain idle timer and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr     <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            rd_en_d1    <= 1'b0;
            Pixel_In    <= '0;
            Pixel_valid <= 1'b0;
            idle_cnt    <= '0;
            error       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_rd_en <= rd_req;
            if (start_acc) begin
                rd_addr  <= '0;
                mem_addr <= '0;
            end else if (rd_req) begin
                mem_addr <= rd_addr;
                rd_addr  <= rd_addr + ADDR_W'(1);
            end

            rd_en_d1    <= mem_rd_en;
            Pixel_valid <= rd_en_d1;
            if (rd_en_d1) begin
                Pixel_In <= mem_data;
            end

            if ((state != ST_DRAIN) || Con_Valid || Max_Valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (start_acc) begin
                error <= 1'b0;
            end else if (conv_over || max_over || timeout) begin
                error <= 1'b1;
            end

            busy <= (state_nxt == ST_STREAM) || (state_nxt == ST_DRAIN);
            done <= (state_nxt == ST_FIN);
        end
    end

    conv_seq_out_counter #(.CNT_W(CNT_W)) u_conv_cnt (
        .clock  (clock),
        .reset  (reset),
        .clr    (start_acc),
        .inc    (Con_Valid && count_en),
        .target (CONV_TGT),
        .count  (conv_count),
        .hit    (conv_hit),
        .over   (conv_over)
    );

    conv_seq_out_counter #(.CNT_W(CNT_W)) u_max_cnt (
        .clock  (clock),
        .reset  (reset),
        .clr    (start_acc),
        .inc    (Max_Valid && count_en),
        .target (MAX_TGT),
        .count  (max_count),
        .hit    (max_hit),
        .over   (max_over)
    );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized bench for conv_frame_sequencer: frame-level behavioural model,
// per-cycle compare on the falling edge, and literal frame-result checks.
module tb_conv_frame_sequencer;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int KERNEL = 3;
    localparam int POOL   = 2;
    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int CONV_W = IMG_W - KERNEL + 1;
    localparam int CONV_H = IMG_H - KERNEL + 1;
    localparam int N_CONV = CONV_W * CONV_H;
    localparam int N_MAX  = (CONV_W / POOL) * (CONV_H / POOL);
    localparam int TMO    = 64;
    localparam int CNT_SAT = 1023;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_data = 8'd0;
    logic [7:0] Pixel_In;
    logic       Pixel_valid;
    logic       Con_Valid = 1'b0;
    logic       Max_Valid = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] conv_count;
    logic [9:0] max_count;

    conv_frame_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .hold        (hold),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .Pixel_In    (Pixel_In),
        .Pixel_valid (Pixel_valid),
        .Con_Valid   (Con_Valid),
        .Max_Valid   (Max_Valid),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .conv_count  (conv_count),
        .max_count   (max_count)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:N_PIX-1];
    always @(posedge clock) begin
        if (mem_rd_en) mem_data <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Datapath stand-in: emits the requested number of pulses at given rates.
    bit gen_en = 0;
    int c_tot = 0, m_tot = 0, c_rate = 0, m_rate = 0;
    int c_sent = 0, m_sent = 0;
    always @(posedge clock) begin
        #2;
        Con_Valid = 1'b0;
        Max_Valid = 1'b0;
        if (!gen_en) begin
            c_sent = 0;
            m_sent = 0;
        end else begin
            if (c_sent < c_tot && $urandom_range(0, 99) < c_rate) begin
                Con_Valid = 1'b1;
                c_sent++;
            end
            if (m_sent < m_tot && $urandom_range(0, 99) < m_rate) begin
                Max_Valid = 1'b1;
                m_sent++;
            end
        end
    end

    // Model of expected behaviour for the current cycle.
    bit m_stream = 0, m_drain = 0, m_fin = 0, m_err = 0;
    bit e_rd = 0, rd_prev = 0, e_pv = 0;
    bit n_stream, n_drain, n_fin, n_rd;
    int rd_left = 0, rd_idx = 0, pix_idx = 0, e_addr = 0, m_idle = 0;
    int m_conv = 0, m_max = 0, old_conv, old_max;
    logic [7:0] last_pix = 8'd0;
    // Per-frame observations.
    int start_cyc = 0, first_pv_cyc = -1, pv_cnt = 0, done_cnt = 0;
    int gap_total = 0, zrun = 0, last_rd_cyc = 0, done_cyc = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_stream = 0; m_drain = 0; m_fin = 0; m_err = 0;
            e_rd = 0; rd_prev = 0; e_pv = 0;
            rd_left = 0; rd_idx = 0; pix_idx = 0; e_addr = 0; m_idle = 0;
            m_conv = 0; m_max = 0; last_pix = 8'd0;
        end else begin
            if (e_pv) begin
                last_pix = (pix_idx < N_PIX) ? mem[pix_idx] : 8'd0;
                pix_idx++;
            end
            chk("mem_rd_en", mem_rd_en, e_rd);
            chk("mem_addr", mem_addr, e_addr);
            chk("Pixel_valid", Pixel_valid, e_pv);
            chk("Pixel_In", Pixel_In, last_pix);
            chk("busy", busy, m_stream || m_drain);
            chk("done", done, m_fin);
            chk("conv_count", conv_count, m_conv);
            chk("max_count", max_count, m_max);
            if (!m_stream && !m_drain) chk("error", error, m_err);

            if (Pixel_valid) begin
                if (first_pv_cyc < 0) first_pv_cyc = cyc;
                if (pv_cnt > 0) gap_total += zrun;
                zrun = 0;
                pv_cnt++;
            end else begin
                zrun++;
            end
            if (mem_rd_en) last_rd_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            n_stream = m_stream; n_drain = m_drain; n_fin = 0; n_rd = 0;
            if (m_fin) begin
                n_stream = 0;
                n_drain  = 0;
            end else if (!m_stream && !m_drain) begin
                if (start) begin
                    n_stream = 1; rd_left = N_PIX; rd_idx = 0; e_addr = 0;
                    pix_idx = 0; m_conv = 0; m_max = 0; m_err = 0;
                    start_cyc = cyc; first_pv_cyc = -1; pv_cnt = 0;
                    done_cnt = 0; gap_total = 0; zrun = 0;
                end
            end else begin
                old_conv = m_conv;
                old_max  = m_max;
                if (Con_Valid) begin
                    if (old_conv == N_CONV) m_err = 1;
                    if (m_conv < CNT_SAT) m_conv++;
                end
                if (Max_Valid) begin
                    if (old_max == N_MAX) m_err = 1;
                    if (m_max < CNT_SAT) m_max++;
                end
                if (m_stream) begin
                    if (!hold) begin
                        n_rd = 1;
                        e_addr = rd_idx;
                        rd_idx++;
                        rd_left--;
                        if (rd_left == 0) begin
                            n_stream = 0;
                            n_drain  = 1;
                            m_idle   = 0;
                        end
                    end
                end else begin
                    if (old_conv == N_CONV && old_max == N_MAX) begin
                        n_drain = 0;
                        n_fin   = 1;
                    end else if (m_idle == TMO) begin
                        n_drain = 0;
                        n_fin   = 1;
                        m_err   = 1;
                    end
                    m_idle = (Con_Valid || Max_Valid) ? 0 : m_idle + 1;
                end
            end
            e_pv = rd_prev;
            rd_prev = e_rd;
            e_rd = n_rd;
            m_stream = n_stream;
            m_drain  = n_drain;
            m_fin    = n_fin;
        end
    end

    task automatic wait_addr(input int a);
        bit found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(posedge clock); #1;
            if (mem_rd_en && mem_addr == 10'(a)) found = 1;
        end
        chk("reach_addr", found, 1);
    endtask

    task automatic start_frame(input int cn, input int mn, input int cr, input int mr);
        @(posedge clock); #1;
        start = 1'b1;
        c_tot = cn; m_tot = mn; c_rate = cr; m_rate = mr;
        @(posedge clock); #1;
        start = 1'b0;
        gen_en = 1;
        chk("start_busy", busy, 1);
        chk("start_err_clr", error, 0);
        chk("start_conv_clr", conv_count, 0);
        chk("start_max_clr", max_count, 0);
    endtask

    task automatic run_frame(input int cn, input int mn, input int cr, input int mr,
                             input int hold_at, input bit poke_fin);
        bit found = 0;
        start_frame(cn, mn, cr, mr);
        if (hold_at >= 0) begin
            wait_addr(hold_at);
            hold = 1'b1;
            repeat (10) @(posedge clock);
            #1 hold = 1'b0;
            repeat (5) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
        end
        for (int k = 0; k < 5000 && !found; k++) begin
            @(posedge clock); #1;
            if (done) found = 1;
        end
        chk("done_seen", found, 1);
        gen_en = 0;
        if (poke_fin) begin
            start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_pix"}, Pixel_In, 0);
        chk({tag, "_pv"}, Pixel_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_conv"}, conv_count, 0);
        chk({tag, "_max"}, max_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_PIX; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Normal frame.
        run_frame(N_CONV, N_MAX, 50, 25, -1, 0);
        chk("A_first_pv_latency", first_pv_cyc - (start_cyc + 1), 3);
        chk("A_pv_total", pv_cnt, 784);
        chk("A_pv_gap", gap_total, 0);
        chk("A_done_cnt", done_cnt, 1);
        chk("A_conv", conv_count, 676);
        chk("A_max", max_count, 169);
        chk("A_err", error, 0);

        // Hold mid-stream plus ignored starts while busy and in FIN.
        run_frame(N_CONV, N_MAX, 50, 25, 300, 1);
        chk("B_pv_total", pv_cnt, 784);
        chk("B_pv_gap", gap_total, 10);
        chk("B_done_cnt", done_cnt, 1);
        chk("B_idle_after", busy, 0);
        chk("B_conv", conv_count, 676);
        chk("B_err", error, 0);

        // Drain timeout after 600 convolution pulses.
        run_frame(600, 150, 100, 50, -1, 0);
        chk("C_conv", conv_count, 600);
        chk("C_max", max_count, 150);
        chk("C_err", error, 1);
        chk("C_tmo_window", (done_cyc - last_rd_cyc) >= 64 && (done_cyc - last_rd_cyc) <= 66, 1);

        // Overrun with coincident pulses; start clears the previous error.
        run_frame(N_CONV + 1, N_MAX, 100, 50, -1, 0);
        chk("D_conv", conv_count, 677);
        chk("D_max", max_count, 169);
        chk("D_err", error, 1);

        // Reset in the middle of a frame.
        start_frame(N_CONV, N_MAX, 50, 25);
        wait_addr(400);
        gen_en = 0;
        done_cnt = 0;
        #1 reset = 1'b1;
        #1 check_all_zero("midreset");
        @(posedge clock);
        #3 reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("E_no_done", done_cnt, 0);

        // Frame after reset restarts from address 0.
        run_frame(N_CONV, N_MAX, 50, 25, -1, 0);
        chk("F_pv_total", pv_cnt, 784);
        chk("F_done_cnt", done_cnt, 1);
        chk("F_conv", conv_count, 676);
        chk("F_err", error, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Sequences one image frame through the convolution/max-pool datapath. On start, it reads IMG_W x IMG_H pixels from a frame memory in raster order and drives them into the datapath pixel input with a valid strobe. It then counts the convolution and max-pool valid pulses coming back, and signals completion or error. It sits between the frame buffer and the conv/max-pool pipeline and replaces bench-style free-running address counters.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
KERNEL, 3, convolution kernel size (valid, stride 1)
POOL, 2, max-pool window and stride
DATA_W, 8, pixel width
ADDR_W, 10, frame memory address width (must hold IMG_W*IMG_H-1)
CNT_W, 10, width of the output counters
DRAIN_TIMEOUT, 64, idle cycles allowed in DRAIN before aborting

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to process a frame; sampled only in IDLE
hold  in  1  stall: while high, no new memory read is issued
mem_rd_en  out  1  frame memory read enable
mem_addr  out  ADDR_W  frame memory read address
mem_data  in  DATA_W  read data, valid one cycle after mem_rd_en
Pixel_In  out  DATA_W  pixel to datapath
Pixel_valid  out  1  pixel qualifier to datapath
Con_Valid  in  1  convolution output valid from datapath
Max_Valid  in  1  max-pool output valid from datapath
busy  out  1  high in STREAM and DRAIN
done  out  1  one-cycle pulse on frame completion (normal or abort)
error  out  1  sticky until next accepted start: timeout or overrun
conv_count  out  CNT_W  Con_Valid pulses seen this frame
max_count  out  CNT_W  Max_Valid pulses seen this frame

Behaviour:
- Constants: N_PIX = IMG_W*IMG_H (784), CONV_W = IMG_W-KERNEL+1 (26), N_CONV = CONV_W*(IMG_H-KERNEL+1) (676), N_MAX = (CONV_W/POOL)*((IMG_H-KERNEL+1)/POOL) (169).
- Reset (async, any state): state=IDLE. All outputs 0, including mem_addr, Pixel_In, counters and the error flag. Internal pipeline valid flags are cleared. A reset mid-frame discards the frame, and no done pulse is produced.
- FSM states: IDLE, STREAM, DRAIN, FIN.
- IDLE: start=1 moves to STREAM. On that edge, counters, error and the read address are cleared to 0.
- STREAM: each cycle with hold=0, assert mem_rd_en with the current mem_addr, then increment the address. With hold=1, mem_rd_en=0 and the address holds. The read at address N_PIX-1 moves the FSM to DRAIN on the same edge. The address never wraps.
- Pixel path latency is 2 cycles from mem_rd_en: rd_en_d1 <= mem_rd_en; Pixel_In <= mem_data when rd_en_d1; Pixel_valid <= rd_en_d1. Pixel_In holds its last value while Pixel_valid=0. Exactly N_PIX Pixel_valid pulses are produced per frame, in address order.
- Counting is active in STREAM and DRAIN. Con_Valid increments conv_count and Max_Valid increments max_count; both counters saturate at all-ones. Both can increment in the same cycle. Pulses in IDLE or FIN are ignored.
- Overrun: a Con_Valid pulse when conv_count==N_CONV, or a Max_Valid pulse when max_count==N_MAX, sets error. The counter still increments, and the frame continues.
- DRAIN: the idle counter resets on any Con_Valid or Max_Valid and increments otherwise.
  - When conv_count==N_CONV and max_count==N_MAX (evaluated on registered counts), go to FIN.
  - Else when the idle counter reaches DRAIN_TIMEOUT, set error and go to FIN.
  - If completion and timeout occur in the same cycle, completion wins and error is not set by the timeout.
- FIN: done=1 for exactly one cycle, then IDLE. Counters and error hold until the next accepted start.
- busy=1 in STREAM and DRAIN only. start while busy or in FIN is ignored (no queuing).

Decomposition:
- Shared package conv_seq_pkg holds:
  - the state encoding (2-bit enum: IDLE, STREAM, DRAIN, FIN);
  - the derived constants N_PIX, N_CONV and N_MAX as functions of the parameters.
- One natural sub-module, conv_seq_out_counter. It is instantiated twice and provides a saturating counter with a target compare and an overrun flag. Inputs are clock, reset, clr, inc and target; outputs are count, hit and over.

Test Plan:
- Normal frame: reset, start pulse, hold=0, model datapath returns 676 Con_Valid and 169 Max_Valid -> exactly 784 Pixel_valid with Pixel_In = mem[0..783] in order; first Pixel_valid 3 cycles after the start edge; done pulses once; conv_count=676, max_count=169, error=0; busy falls with done.
- Hold mid-stream: assert hold for 10 cycles at address 300 -> no mem_rd_en during hold; the Pixel_valid gap is exactly 10 cycles, shifted by 2; pixel order is intact and the total is still 784.
- Start while busy: second start pulse during STREAM and in the FIN cycle -> ignored; one done only; the address does not restart.
- Drain timeout: datapath stops after 600 Con_Valid -> 64 idle cycles in DRAIN, then done=1, error=1, conv_count=600; the next start clears error and counters.
- Overrun and simultaneity: Con_Valid and Max_Valid asserted in the same cycle both count; a 677th Con_Valid sets error with conv_count=677.
- Reset mid-frame: reset asserted at address 400 -> all outputs 0 immediately (async) and no done; the next start streams from address 0.
